instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming instruction encoder and program loader for the RISC processor, the write-side counterpart of the instruction field decoder. It accepts instruction fields with a format tag over a valid/ready handshake and packs them into 32-bit words using the processor's field layout. It writes the words sequentially into instruction memory through a single write port. The testbench and boot path use it to load programs before the core is released.

## Interface
- `ADDR_W`, default 8: instruction memory word-address width.
- `LAST_ADDR`, default 255: highest address the loader may write (≤ 2^ADDR_W−1).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a load at `base_addr`; honoured in IDLE or DONE, ignored in LOAD.
- `base_addr`, in, ADDR_W: first write address, sampled with `start`.
- `stop`, in, 1: end the load early; honoured in LOAD.
- `in_valid`, in, 1: field set valid.
- `in_ready`, out, 1: encoder can accept a field set.
- `fmt`, in, 2: field format. 00 R, 01 I, 10 M, 11 J.
- `op`, in, 6: opcode.
- `rs`, in, 5: source register.
- `rt`, in, 5: target register.
- `sh`, in, 5: shift amount.
- `fn`, in, 11: function code.
- `imm`, in, 21: immediate. I uses [15:0] as offset; M uses all 21 bits.
- `jtr`, in, 26: jump target.
- `mem_we`, out, 1: instruction memory write enable.
- `mem_addr`, out, ADDR_W: write address.
- `mem_wdata`, out, 32: encoded instruction.
- `busy`, out, 1: high in LOAD.
- `done`, out, 1: high in DONE.
- `count`, out, ADDR_W+1: words written since the last accepted `start`.
- `checksum`, out, 32: XOR of written words (see Configuration).

## Operation
- Word packing (op always at [31:26]):
  - R: {op, rs, rt, sh, fn}
  - I: {op, rs, rt, imm[15:0]}
  - M: {op, rs, imm[20:0]}
  - J: {op, jtr}
  - Unused input bits are ignored.
- States are IDLE, LOAD and DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1:
  - If `base_addr` ≤ LAST_ADDR: go to LOAD, set write pointer to `base_addr`, clear `count` and `checksum`.
  - If `base_addr` > LAST_ADDR: go to DONE with no writes and `count`=0.
- LOAD:
  - `in_ready`=1, decoded from registered state only.
  - Accept occurs when `in_valid` and `in_ready` are both high. On accept: register the packed word and current pointer, increment the pointer, increment `count`.
  - An accept at pointer = LAST_ADDR moves the FSM to DONE. The pointer never wraps.
  - `stop`=1 moves the FSM to DONE. If an accept happens in the same cycle, that word is still written.
- DONE:
  - `in_ready`=0 and `done` is held until the next `start`.
  - The last word's write completes in the first DONE cycle.
- `in_valid` may drop between transfers. Idle cycles do not produce writes.

## Timing
- Write latency: 1 cycle. An accept at edge N gives `mem_we`=1 with address and data valid for the cycle after edge N.
- `mem_we` is a one-cycle pulse per accepted word. Throughput is 1 word per cycle.
- `in_ready` falls in the cycle after the final accept, so no extra word is ever accepted.
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `count` 0, `checksum` 0.
- Asserting `rst_n` mid-load drops `mem_we` immediately and discards a pending write.
- `count` and `checksum` update in the same cycle as the corresponding `mem_we`.

## Configuration
- `INSTR_ENC_CHECKSUM_EN` defined:
  - `checksum` ^= `mem_wdata` on every write.
  - Cleared on an accepted `start`.
- Undefined: no checksum register is built and `checksum` is tied to 32'h0. All other behaviour is identical.

## Test plan
- R-format encode: reset, `start` with base 0, fmt 00, op 6'h01, rs 3, rt 4, sh 2, fn 11'h005 → next cycle `mem_we`=1, `mem_addr` 0, `mem_wdata` 32'h04641005, `count` 1.
- I and J formats: op 6'h23, rs 1, rt 2, imm 21'h1FFFF → 32'h8C22FFFF. Then op 6'h02, jtr 26'h100 → 32'h08000100 at the next address.
- Wrap guard: LAST_ADDR 3, base 2, `in_valid` held high with 3 field sets → writes only at 2 and 3, `in_ready` low after the 2nd accept, `done`=1, `count` 2.
- Early stop: `stop` asserted in the same cycle as an accept → that word is written, DONE next cycle, no further `mem_we`.
- Reset mid-load: `rst_n` low while `mem_we` is pending → all outputs 0 immediately, IDLE after release. `start` with base 10 > LAST_ADDR 3 → `done`=1, `count` 0, no writes.
- Checksum (macro defined): write 32'h04641005 then 32'h08000100 → `checksum` 32'h0C641105. Without the macro → `checksum` stays 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming instruction encoder and program loader: packs R/I/M/J field sets into
// 32-bit words and writes them sequentially into instruction memory.
// Optional running XOR checksum of written words: define INSTR_ENC_CHECKSUM_EN.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        sh,
    input  logic [10:0]       fn,
    input  logic [20:0]       imm,
    input  logic [25:0]       jtr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       packed_word;
    logic              accept;
    logic              start_acc;

    always_comb begin
        packed_word = 32'h0;
        case (fmt)
            2'b00:   packed_word = {op, rs, rt, sh, fn};
            2'b01:   packed_word = {op, rs, rt, imm[15:0]};
            2'b10:   packed_word = {op, rs, imm};
            default: packed_word = {op, jtr};
        endcase
    end

    // in_ready depends only on registered state, never on in_valid or stop.
    assign in_ready  = (state_q == LOAD);
    assign accept    = in_ready && in_valid;
    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d = '0;
                    if (base_addr <= LastAddr) begin
                        state_d = LOAD;
                        ptr_d   = base_addr;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = packed_word;
                    count_d = count_q + 1'b1;
                    // Stop at the last address instead of wrapping the pointer.
                    if (ptr_q == LastAddr) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                if (stop) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    // Folded in at accept time so it moves together with mem_we and count.
    always_comb begin
        sum_d = sum_q;
        if (start_acc) begin
            sum_d = 32'h0;
        end else if (accept) begin
            sum_d = sum_q ^ packed_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 32'h0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign checksum         = 32'h0;
`endif

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == LOAD);
    assign done      = (state_q == DONE);
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural loader model.
module tb_instr_encoder;

    localparam int ADDR_W    = 4;
    localparam int LAST_ADDR = 11;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              stop;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        sh;
    logic [10:0]       fn;
    logic [20:0]       imm;
    logic [25:0]       jtr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic [31:0]       checksum;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a loading flag, a finished flag, the next address,
    // the number of words written and their XOR.
    bit          mLoading;
    bit          mFinished;
    int          mPtr;
    int          mCount;
    logic [31:0] mSum;
    bit          mWe;
    int          mAddr;
    logic [31:0] mData;

    instr_encoder #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .stop(stop), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .op(op), .rs(rs), .rt(rt), .sh(sh), .fn(fn), .imm(imm), .jtr(jtr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .count(count), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] packWord(input logic [1:0] f, input logic [5:0] o,
                                             input logic [4:0] a, input logic [4:0] b,
                                             input logic [4:0] s, input logic [10:0] c,
                                             input logic [20:0] i, input logic [25:0] j);
        logic [31:0] w;
        w = 32'(o) << 26;
        case (f)
            2'd0:    w = w | (32'(a) << 21) | (32'(b) << 16) | (32'(s) << 11) | 32'(c);
            2'd1:    w = w | (32'(a) << 21) | (32'(b) << 16) | (32'(i) & 32'h0000FFFF);
            2'd2:    w = w | (32'(a) << 21) | 32'(i);
            default: w = w | 32'(j);
        endcase
        return w;
    endfunction

    function automatic logic [31:0] expectedSum();
`ifdef INSTR_ENC_CHECKSUM_EN
        return mSum;
`else
        return 32'h0;
`endif
    endfunction

    task automatic applyStimulus(input bit st, input int base, input bit sp, input bit v,
                                 input logic [1:0] f, input logic [5:0] o,
                                 input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] s, input logic [10:0] c,
                                 input logic [20:0] i, input logic [25:0] j);
        start     = st;
        base_addr = ADDR_W'(base);
        stop      = sp;
        in_valid  = v;
        fmt = f; op = o; rs = a; rt = b; sh = s; fn = c; imm = i; jtr = j;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'd0);
    endtask

    task automatic modelReset();
        mLoading = 1'b0; mFinished = 1'b0; mPtr = 0; mCount = 0;
        mSum = 32'h0; mWe = 1'b0; mAddr = 0; mData = 32'h0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT and compare.
    task automatic stepCycle();
        bit          acc;
        logic [31:0] w;
        acc = mLoading && in_valid;
        w   = packWord(fmt, op, rs, rt, sh, fn, imm, jtr);
        mWe = acc;
        if (acc) begin
            mAddr = mPtr;
            mData = w;
        end
        if (mLoading) begin
            if (acc) begin
                mCount++;
                mSum = mSum ^ w;
                if (mPtr == LAST_ADDR) begin
                    mLoading = 1'b0; mFinished = 1'b1;
                end else begin
                    mPtr++;
                end
            end
            if (stop) begin
                mLoading = 1'b0; mFinished = 1'b1;
            end
        end else if (start) begin
            mCount = 0;
            mSum   = 32'h0;
            if (int'(base_addr) <= LAST_ADDR) begin
                mLoading = 1'b1; mFinished = 1'b0; mPtr = int'(base_addr);
            end else begin
                mLoading = 1'b0; mFinished = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(mLoading));
        checkOutput("busy", 32'(busy), 32'(mLoading));
        checkOutput("done", 32'(done), 32'(mFinished));
        checkOutput("mem_we", 32'(mem_we), 32'(mWe));
        if (mWe) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(mAddr));
            checkOutput("mem_wdata", mem_wdata, mData);
        end
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("checksum", checksum, expectedSum());
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_count"}, 32'(count), 32'h0);
        checkOutput({tag, "_checksum"}, checksum, 32'h0);
    endtask

    initial begin
        modelReset();
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkAllZero("reset");
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R then J format from base 0, with the two-word checksum anchor
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'd0);
        stepCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd0, 6'h01, 5'd3, 5'd4, 5'd2, 11'h005, 21'd0, 26'd0);
        stepCycle();
        checkOutput("r_word", mem_wdata, 32'h04641005);
        checkOutput("r_addr", 32'(mem_addr), 32'h0);
        checkOutput("r_count", 32'(count), 32'h1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'h100);
        stepCycle();
        checkOutput("j_word", mem_wdata, 32'h08000100);
        checkOutput("j_addr", 32'(mem_addr), 32'h1);
`ifdef INSTR_ENC_CHECKSUM_EN
        checkOutput("sum_anchor", checksum, 32'h0C641105);
`else
        checkOutput("sum_anchor", checksum, 32'h0);
`endif
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd1, 6'h23, 5'd1, 5'd2, 5'd0, 11'd0, 21'h1FFFF, 26'd0);
        stepCycle();
        checkOutput("i_word", mem_wdata, 32'h8C22FFFF);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'd0);
        stepCycle();
        idleInputs();
        stepCycle();

        // Last-address guard: three field sets offered, only two fit
        applyStimulus(1'b1, LAST_ADDR - 1, 1'b0, 1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'd0);
        stepCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd2, 6'(k + 7), 5'(k), 5'd0, 5'd0, 11'd0,
                          21'h155AA, 26'd0);
            stepCycle();
        end
        checkOutput("guard_done", 32'(done), 32'h1);
        checkOutput("guard_count", 32'(count), 32'h2);
        idleInputs();
        stepCycle();

        // Stop in the same cycle as an accept
        applyStimulus(1'b1, 4, 1'b0, 1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'd0);
        stepCycle();
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 2'd0, 6'h11, 5'd9, 5'd8, 5'd7, 11'h3FF, 21'd0, 26'd0);
        stepCycle();
        checkOutput("stop_we", 32'(mem_we), 32'h1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd0, 6'h12, 5'd1, 5'd1, 5'd1, 11'h1, 21'd0, 26'd0);
        stepCycle();
        stepCycle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6),
                          2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 11'($urandom), 21'($urandom), 26'($urandom));
            stepCycle();
        end

        // Reset while a write is pending
        idleInputs();
        stepCycle();
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'd0);
        stepCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd3, 6'h3F, 5'd0, 5'd0, 5'd0, 11'd0, 21'd0, 26'h3FFFFFF);
        stepCycle();
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        #2;
        rst_n = 1'b1;
        modelReset();
        stepCycle();

        // Out-of-range base: straight to DONE, nothing written
        applyStimulus(1'b1, LAST_ADDR + 2, 1'b0, 1'b1, 2'd0, 6'h01, 5'd1, 5'd1, 5'd1, 11'd1, 21'd0, 26'd0);
        stepCycle();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 2'd0, 6'h01, 5'd1, 5'd1, 5'd1, 11'd1, 21'd0, 26'd0);
        for (int k = 0; k < 3; k++) stepCycle();
        checkOutput("oor_done", 32'(done), 32'h1);
        checkOutput("oor_count", 32'(count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
